// File: rtl/big_alu.sv
// Sign-magnitude add/subtract core for the FP adder significand path.
// Single registered stage; data outputs hold whenever no operation is issued.
module big_alu #(
    parameter int unsigned DATA_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  sign_a,
    input  logic                  sign_b,
    input  logic                  symbol,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  cout,
    output logic                  sign_out,
    output logic                  zero
);

    logic                  eff_sub;
    logic [DATA_WIDTH:0]   sum;
    logic [DATA_WIDTH:0]   diff_ab;
    logic [DATA_WIDTH-1:0] diff_ba;
    logic                  a_lt_b;

    logic [DATA_WIDTH-1:0] res_mag;
    logic                  res_cout;
    logic                  res_sign;

    logic                  valid_d, valid_q;
    logic [DATA_WIDTH-1:0] out_d, out_q;
    logic                  cout_d, cout_q;
    logic                  sign_d, sign_q;
    logic                  zero_d, zero_q;

    always_comb begin
        eff_sub = sign_a ^ sign_b ^ symbol;
        sum     = {1'b0, a} + {1'b0, b};
        // The extra top bit of a-b acts as the borrow, i.e. a < b.
        diff_ab = {1'b0, a} - {1'b0, b};
        diff_ba = b - a;
        a_lt_b  = diff_ab[DATA_WIDTH];
    end

    always_comb begin
        res_mag  = sum[DATA_WIDTH-1:0];
        res_cout = sum[DATA_WIDTH];
        res_sign = sign_a;
        if (eff_sub) begin
            res_cout = 1'b0;
            if (a_lt_b) begin
                res_mag  = diff_ba;
                res_sign = ~sign_a;
            end else begin
                res_mag  = diff_ab[DATA_WIDTH-1:0];
                // Exact cancellation yields +0.
                res_sign = (diff_ab[DATA_WIDTH-1:0] == '0) ? 1'b0 : sign_a;
            end
        end
    end

    always_comb begin
        valid_d = in_valid;
        out_d   = out_q;
        cout_d  = cout_q;
        sign_d  = sign_q;
        zero_d  = zero_q;
        if (in_valid) begin
            out_d  = res_mag;
            cout_d = res_cout;
            sign_d = res_sign;
            zero_d = (res_mag == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            out_q   <= '0;
            cout_q  <= 1'b0;
            sign_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            out_q   <= out_d;
            cout_q  <= cout_d;
            sign_q  <= sign_d;
            zero_q  <= zero_d;
        end
    end

    assign out_valid = valid_q;
    assign out       = out_q;
    assign cout      = cout_q;
    assign sign_out  = sign_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_big_alu.sv
// Scoreboard bench for big_alu: expected results are queued at issue time
// and compared one cycle later when the DUT presents them.
module tb_big_alu;

    localparam int unsigned W = 24;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] a, b;
    logic         sign_a, sign_b, symbol;
    logic         out_valid;
    logic [W-1:0] out;
    logic         cout, sign_out, zero;

    typedef struct packed {
        logic [W-1:0] mag;
        logic         c;
        logic         s;
        logic         z;
    } res_t;

    res_t exp_q[$];
    res_t last_exp;
    int   errors = 0;
    int   checks = 0;

    big_alu #(.DATA_WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .sign_a    (sign_a),
        .sign_b    (sign_b),
        .symbol    (symbol),
        .out_valid (out_valid),
        .out       (out),
        .cout      (cout),
        .sign_out  (sign_out),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic sa, input logic sym, input logic sb);
        res_t   r;
        longint la, lb, s;
        la = longint'(ma);
        lb = longint'(mb);
        if ((sa ^ sym ^ sb) == 1'b0) begin
            s     = la + lb;
            r.mag = W'(s % (longint'(1) << W));
            r.c   = (s >= (longint'(1) << W));
            r.s   = sa;
        end else if (la >= lb) begin
            r.mag = W'(la - lb);
            r.c   = 1'b0;
            r.s   = (la == lb) ? 1'b0 : sa;
        end else begin
            r.mag = W'(lb - la);
            r.c   = 1'b0;
            r.s   = ~sa;
        end
        r.z = (r.mag == '0);
        return r;
    endfunction

    task automatic cmp_outputs(input string tag, input res_t r);
        check({tag, ".out"},  64'(out),      64'(r.mag));
        check({tag, ".cout"}, 64'(cout),     64'(r.c));
        check({tag, ".sign"}, 64'(sign_out), 64'(r.s));
        check({tag, ".zero"}, 64'(zero),     64'(r.z));
    endtask

    // Advance one edge, then sample 1 time unit after it.
    task automatic step();
        logic ev;
        res_t r;
        ev = in_valid;
        @(posedge clk);
        #1;
        check("out_valid", 64'(out_valid), 64'(ev));
        if (ev) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 64'(1), 64'(0));
            end else begin
                r = exp_q.pop_front();
                cmp_outputs("result", r);
                last_exp = r;
            end
        end else begin
            cmp_outputs("hold", last_exp);
        end
    endtask

    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic sa, input logic sym, input logic sb);
        a        = ia;
        b        = ib;
        sign_a   = sa;
        symbol   = sym;
        sign_b   = sb;
        in_valid = 1'b1;
        exp_q.push_back(model(ia, ib, sa, sym, sb));
        step();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        step();
    endtask

    task automatic check_reset_zero(input string tag);
        check({tag, ".out_valid"}, 64'(out_valid), 64'(0));
        check({tag, ".out"},       64'(out),       64'(0));
        check({tag, ".cout"},      64'(cout),      64'(0));
        check({tag, ".sign"},      64'(sign_out),  64'(0));
        check({tag, ".zero"},      64'(zero),      64'(0));
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        sign_a   = 1'b0;
        sign_b   = 1'b0;
        symbol   = 1'b0;
        last_exp = '0;
        #12;
        check_reset_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed vectors, issued back to back.
        issue(24'd100,      24'd215,      1'b0, 1'b0, 1'b0);
        issue(24'd16777210, 24'd20,       1'b0, 1'b0, 1'b0);
        issue(24'd100,      24'd16777210, 1'b1, 1'b1, 1'b0);
        issue(24'd215,      24'd100,      1'b0, 1'b0, 1'b1);
        issue(24'd85,       24'd215,      1'b0, 1'b0, 1'b1);
        issue(24'd126,      24'd215,      1'b0, 1'b1, 1'b0);
        issue(24'd126,      24'd215,      1'b1, 1'b1, 1'b1);
        issue(24'd215,      24'd100,      1'b1, 1'b0, 1'b0);
        issue(24'd500,      24'd500,      1'b1, 1'b1, 1'b1);
        // Zero sum keeps the sign of A.
        issue(24'd0,        24'd0,        1'b1, 1'b0, 1'b1);
        idle();
        idle();

        // Random operations with occasional bubbles and equal operands.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle();
            end else begin
                ra = W'($urandom);
                rb = ($urandom_range(0, 4) == 0) ? ra : W'($urandom);
                issue(ra, rb, 1'($urandom), 1'($urandom), 1'($urandom));
            end
        end

        // Asynchronous reset between edges while a result is valid.
        issue(24'd300, 24'd45, 1'b1, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        check_reset_zero("async_reset");
        exp_q.delete();
        last_exp = '0;
        idle();
        rst = 1'b0;
        idle();
        issue(24'd7, 24'd9, 1'b0, 1'b0, 1'b1);
        idle();

        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
